sec32_check_encoder: RTL
========================

# sec32_check_encoder

Streaming check-bit generator for the 32-bit single-error-correcting datapath. The encoder takes 32-bit data words over a valid/ready handshake and emits each word with its 8 check bits and the check-enable flag. The output is exactly what the downstream SEC corrector consumes: for an unmodified word, every one of the corrector's eight syndromes evaluates to zero. The block is a two-stage registered pipeline with backpressure and a wrapping word counter. An optional error injector lets the corrector be exercised end to end.

## Interface
- No parameters; widths are fixed by the SEC code (32 data, 8 check).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  encoder accepts the word this cycle.
- `in_data`  in  32  data word. `d[k]` maps to corrector data input N(1+4k).
- `out_valid`  out  1  encoded word present.
- `out_ready`  in  1  downstream accepts the word.
- `out_data`  out  32  data word, possibly with an injected flip.
- `out_check`  out  8  check bits. `c[i]` maps to corrector input N(129+i).
- `out_chk_en`  out  1  corrector enable (N137). Equals `out_valid`.
- `word_cnt`  out  16  count of words delivered on the output.
- `inj_req`, `inj_pos[5:0]`, `inj_busy`  (SEC32_ERR_INJECT_EN only; see Configuration).

## Operation
- Groups: G(a..b) is the XOR of `d[a]..d[b]`. Q(j) is `d[j]^d[j+4]^d[j+8]^d[j+12]`. R(j) is `d[16+j]^d[20+j]^d[24+j]^d[28+j]`.
- c0 = G(16..23)^Q(0)
- c1 = G(24..31)^Q(1)
- c2 = G(16..19)^G(24..27)^Q(2)
- c3 = G(20..23)^G(28..31)^Q(3)
- c4 = G(0..7)^R(0)
- c5 = G(8..15)^R(1)
- c6 = G(0..3)^G(8..11)^R(2)
- c7 = G(4..7)^G(12..15)^R(3)
- Stage 1 (S1) registers the data and the 16 partial parities: eight nibble parities plus Q(0..3) and R(0..3).
- Stage 2 (S2) registers the data and the final `c[7:0]`. S2 is the output register.
- Each stage holds a valid bit. A stage loads when it is empty or when its contents advance in the same cycle, so bubbles collapse.
- `in_ready` = !S1.valid | (S2 loads this cycle).
- S2 loads when S1.valid & (!S2.valid | out_ready).
- Order is strictly FIFO. No word is dropped or duplicated.
- `word_cnt` increments on each `out_valid & out_ready`. It wraps from 0xFFFF to 0x0000.

## Timing
- Latency: a word accepted at edge N appears on `out_valid` after edge N+1, provided there is no stall.
- Throughput: one word per cycle with `out_ready` held high.
- Under stall (`out_ready`=0), S2 holds `out_data`/`out_check` stable. S1 fills, then `in_ready` drops. At most 2 words are in flight.
- Simultaneous output pop and input push when both stages are full: S2 takes the S1 word and S1 takes the new word in the same edge.
- Reset (async, any cycle, including mid-stall): both valid bits clear and the in-flight words are discarded.
- Reset values: `out_valid`=0, `out_chk_en`=0, `out_data`=0, `out_check`=0, `word_cnt`=0, `inj_busy`=0.
- `in_ready` is 1 in the first cycle after reset is released.

## Configuration
- `SEC32_ERR_INJECT_EN` defined:
  - `inj_req` (in, 1) and `inj_pos` (in, 6) arm a single-shot flip. Arming is captured on an edge where `inj_req`=1 and `inj_busy`=0.
  - `inj_busy` (out, 1) is high while the flip is armed.
  - The flip is applied to the next word loaded into S2.
    - `inj_pos` 0..31 inverts `out_data[inj_pos]`.
    - `inj_pos` 32..39 inverts `out_check[inj_pos-32]`.
    - `inj_pos` 40..63 flips nothing.
  - In every case `inj_busy` clears on that S2 load.
  - `inj_req` while `inj_busy`=1 is ignored.
  - Arming in the same cycle as an S2 load applies to the following load, not the current one.
- `SEC32_ERR_INJECT_EN` undefined: the three injection ports are absent and output words are never modified.

## Test plan
- Reset, then push `0x00000000` -> `out_check`=0x00 and `out_chk_en`=1 two cycles after acceptance; `word_cnt`=1 after the pop.
- Push `0x00000001` -> `out_check`=0x51. Push `0x80000000` -> `out_check`=0x8A. Push `0xFFFFFFFF` -> `out_check`=0x00.
- Back-to-back stream of 100 random words with `out_ready`=1 -> one output per cycle, in order. Each (data, check) pair fed to the SEC corrector with N137=1 returns the data unchanged.
- Hold `out_ready`=0 while pushing -> `in_ready` falls after 2 accepts and output stays stable. Release -> words drain in order with no loss.
- Preload `word_cnt` to 0xFFFF via 65535 pops, then one more pop -> 0x0000. Assert `rst` mid-stall -> `out_valid`=0 immediately and `word_cnt`=0.
- With SEC32_ERR_INJECT_EN: arm `inj_pos`=5, push `0x00000000` -> `out_data`=0x00000020 and `out_check`=0x00; corrector output is 0x00000000; `inj_busy` clears. Arm `inj_pos`=45 -> the next word passes unmodified.

Source files
------------

// File: rtl/sec32_check_encoder.sv
// sec32_check_encoder
//   Two-stage pipelined check-bit generator for the 32-bit SEC datapath.
//   Each accepted word leaves with 8 check bits chosen so that every syndrome
//   of the downstream corrector is zero for an unmodified word.
//
//   Optional feature macro: SEC32_ERR_INJECT_EN (single-shot bit-flip injector).
//
// Ports
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready   input handshake, in_data[31:0] data word
//   out_valid/out_ready output handshake
//   out_data[31:0]      data word (possibly with an injected flip)
//   out_check[7:0]      check bits
//   out_chk_en          corrector enable, mirrors out_valid
//   word_cnt[15:0]      wrapping count of delivered words
//   inj_req, inj_pos[5:0], inj_busy   injector (SEC32_ERR_INJECT_EN only)

module sec32_check_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [7:0]  out_check,
  output logic        out_chk_en,
  output logic [15:0] word_cnt
`ifdef SEC32_ERR_INJECT_EN
  ,
  input  logic        inj_req,
  input  logic [5:0]  inj_pos,
  output logic        inj_busy
`endif
);

  logic        s1_valid;
  logic [31:0] s1_data;
  logic [7:0]  s1_nib;
  logic [3:0]  s1_q;
  logic [3:0]  s1_r;

  logic        s2_valid;
  logic [31:0] s2_data;
  logic [7:0]  s2_check;

  logic        s1_load;
  logic        s2_load;

  logic [7:0]  nib;
  logic [3:0]  q;
  logic [3:0]  r;
  logic [7:0]  check;

  logic [31:0] data_flip;
  logic [7:0]  check_flip;

  // Partial parities of the incoming word.
  always_comb begin
    nib = '0;
    q   = '0;
    r   = '0;
    for (int i = 0; i < 8; i++) begin
      nib[i] = ^in_data[4*i +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      q[j] = in_data[j]    ^ in_data[j+4]  ^ in_data[j+8]  ^ in_data[j+12];
      r[j] = in_data[16+j] ^ in_data[20+j] ^ in_data[24+j] ^ in_data[28+j];
    end
  end

  // Final check bits from the stage-1 partials (nibble k covers d[4k+3:4k]).
  always_comb begin
    check    = '0;
    check[0] = s1_nib[4] ^ s1_nib[5] ^ s1_q[0];
    check[1] = s1_nib[6] ^ s1_nib[7] ^ s1_q[1];
    check[2] = s1_nib[4] ^ s1_nib[6] ^ s1_q[2];
    check[3] = s1_nib[5] ^ s1_nib[7] ^ s1_q[3];
    check[4] = s1_nib[0] ^ s1_nib[1] ^ s1_r[0];
    check[5] = s1_nib[2] ^ s1_nib[3] ^ s1_r[1];
    check[6] = s1_nib[0] ^ s1_nib[2] ^ s1_r[2];
    check[7] = s1_nib[1] ^ s1_nib[3] ^ s1_r[3];
  end

  assign s2_load  = s1_valid & (~s2_valid | out_ready);
  assign in_ready = ~s1_valid | s2_load;
  assign s1_load  = in_valid & in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_nib   <= '0;
      s1_q     <= '0;
      s1_r     <= '0;
    end else begin
      if (s1_load) begin
        s1_valid <= 1'b1;
        s1_data  <= in_data;
        s1_nib   <= nib;
        s1_q     <= q;
        s1_r     <= r;
      end else if (s2_load) begin
        s1_valid <= 1'b0;
      end
    end
  end

`ifdef SEC32_ERR_INJECT_EN
  logic [5:0] inj_pos_q;

  // A flip is applied only if it was armed before this S2 load, so arming
  // during a load naturally targets the following word.
  always_comb begin
    data_flip  = '0;
    check_flip = '0;
    if (inj_busy) begin
      if (inj_pos_q[5] == 1'b0) begin
        data_flip[inj_pos_q[4:0]] = 1'b1;
      end else if (inj_pos_q[4:3] == 2'b00) begin
        check_flip[inj_pos_q[2:0]] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inj_busy  <= 1'b0;
      inj_pos_q <= '0;
    end else begin
      if (inj_busy && s2_load) begin
        inj_busy <= 1'b0;
      end else if (!inj_busy && inj_req) begin
        inj_busy  <= 1'b1;
        inj_pos_q <= inj_pos;
      end
    end
  end
`else
  assign data_flip  = '0;
  assign check_flip = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_check <= '0;
    end else begin
      if (s2_load) begin
        s2_valid <= 1'b1;
        s2_data  <= s1_data ^ data_flip;
        s2_check <= check ^ check_flip;
      end else if (out_ready) begin
        s2_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (s2_valid && out_ready) begin
      word_cnt <= word_cnt + 16'd1;
    end
  end

  assign out_valid  = s2_valid;
  assign out_chk_en = s2_valid;
  assign out_data   = s2_data;
  assign out_check  = s2_check;

endmodule
